ppi_bus_sequencer: RTL and testbench
====================================

Name: ppi_bus_sequencer

Overview:
- Upstream host-side controller for the 8255-style PPI chip.
- Turns a simple valid/ready request stream (read or write, 2-bit register address, 8-bit data) into correctly timed PPI bus cycles on CSbar/RDbar/WRbar/Addresslines/data.
- Returns read data or write acknowledges on a response strobe.
- Generates the PPI's active-high RESET pulse after its own reset.
- The data bus is split into out/oe/in; the top level builds the tristate.

Parameters:
- FIFO_DEPTH, 2, request buffer entries (power of two, 2..8).
- INIT_CYC, 4, cycles ppi_reset is held high after RESET release (1..15).
- SETUP_CYC, 1, cycles CS_n/address/data are valid before the strobe (1..15).
- STROBE_CYC, 2, cycles RD_n or WR_n is held low (1..15).
- HOLD_CYC, 1, cycles CS_n/address/data are held after the strobe (1..15).
- RECOVER_CYC, 1, idle cycles with CS_n high between bus cycles (1..15).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&&ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  2  PPI register: 00 = A, 01 = B, 10 = C, 11 = control.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  8  read data; 0 for writes and errors.
- rsp_err  out  1  qualifies rsp_valid; illegal request.
- busy  out  1  FIFO non-empty or state != IDLE.
- ppi_reset  out  1  drives PPI RESET (active-high).
- ppi_cs_n  out  1  PPI CSbar.
- ppi_rd_n  out  1  PPI RDbar.
- ppi_wr_n  out  1  PPI WRbar.
- ppi_addr  out  2  PPI Addresslines.
- ppi_d_out  out  8  data driven to the PPI data port.
- ppi_d_oe  out  1  1 = drive ppi_d_out onto the bus.
- ppi_d_in  in  8  data sampled from the PPI data port.

Behaviour:

Reset and outputs
- Applying RESET=0 sets, at the next edge:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1.
  - ppi_reset=1, ppi_cs_n=1, ppi_rd_n=1, ppi_wr_n=1, ppi_addr=00, ppi_d_out=0, ppi_d_oe=0.
  - FIFO is flushed; state=INIT; counter loaded with INIT_CYC.
- Reset mid-cycle aborts the bus cycle immediately; no response is issued for any pending request.
- All outputs are registered.

Request FIFO
- req_ready = !full && state != INIT.
- Push on valid&&ready.
- Pop occurs only in IDLE when non-empty. The popped entry is latched as the current request and the FIFO frees that slot the same cycle.
- Push and pop in the same cycle are legal when full is not blocking the push; occupancy is unchanged.

State machine: INIT -> IDLE -> SETUP -> STROBE -> HOLD -> RECOVER -> IDLE
- Each timed state lasts exactly its parameter's number of cycles (down-counter, 4 bits).
- INIT: ppi_reset=1 for INIT_CYC cycles after RESET release, then 0; go to IDLE.
- IDLE, on pop:
  - Read with addr=11 is illegal. It skips the bus cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0 on the next cycle, then returns to IDLE (no RECOVER).
  - Otherwise go to SETUP.
- SETUP: cs_n=0, ppi_addr=req addr. For writes, d_oe=1 and d_out=wdata.
- STROBE: rd_n=0 (read) or wr_n=0 (write). cs_n/addr/d_out/d_oe unchanged.
  - Reads sample ppi_d_in at the rising edge ending the last STROBE cycle.
- HOLD: rd_n=wr_n=1. cs_n, addr and d_oe held.
  - rsp_valid=1 during the first HOLD cycle with rsp_err=0; rsp_rdata = sampled data (read) or 0 (write).
- RECOVER: cs_n=1, d_oe=0. ppi_addr keeps its last value.

Invariants
- rd_n and wr_n are never low together.
- A strobe is never low while cs_n=1.
- d_oe is never 1 during a read cycle.

Cycle counts (defaults)
- Bus cycle: cs_n low 4 cycles. Request-to-request: 5 cycles plus 1 pop cycle.

Decomposition:
- Package ppi_pkg:
  - Address constants ADDR_A=2'b00, ADDR_B=2'b01, ADDR_C=2'b10, ADDR_CTRL=2'b11.
  - State enum {INIT, IDLE, SETUP, STROBE, HOLD, RECOVER}.
  - Request struct {wr, addr[1:0], wdata[7:0]} (11 bits).
- Sub-module ppi_req_fifo:
  - Synchronous FIFO of request structs, parameter FIFO_DEPTH.
  - Ports push/pop/full/empty/dout; same synchronous active-low RESET.
- The sequencer FSM lives in ppi_bus_sequencer.

Test Plan:
1. Reset release, defaults -> ppi_reset high exactly 4 cycles; req_ready=0 during those cycles, 1 after; all strobes high throughout.
2. Write addr=00, wdata=AA -> cs_n low 4 cycles, wr_n low cycles 2–3, d_oe=1 with d_out=AA for all 4; rsp_valid one cycle with rdata=00, err=0.
3. Read addr=01 with bench driving ppi_d_in=5C only while rd_n=0 -> rsp_valid with rdata=5C; d_oe stays 0; rd_n low exactly 2 cycles.
4. Back-to-back: 3 requests presented continuously (write 11=80, write 00=3C, read 10) -> req_ready drops when FIFO is full; all 3 executed in order; RECOVER gap of 1 cycle with cs_n=1 between cycles.
5. Read addr=11 -> no cs_n assertion; rsp_valid with err=1, rdata=00.
6. RESET=0 during STROBE of a write -> next edge wr_n=1, cs_n=1, d_oe=0, FIFO empty; no rsp_valid; INIT pulse repeats after release.

Source files
------------

// File: rtl/ppi_pkg.sv
// Shared types for the 8255 PPI host-side bus sequencer: register
// addresses, FSM states and the buffered request format.
package ppi_pkg;

  localparam logic [1:0] ADDR_A    = 2'b00;
  localparam logic [1:0] ADDR_B    = 2'b01;
  localparam logic [1:0] ADDR_C    = 2'b10;
  localparam logic [1:0] ADDR_CTRL = 2'b11;

  typedef enum logic [2:0] {INIT, IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  typedef struct packed {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
  } ppi_req_t;

  // The control word register is write-only on the 8255.
  function automatic logic is_illegal(ppi_req_t r);
    return !r.wr && (r.addr == ADDR_CTRL);
  endfunction

endpackage

// File: rtl/ppi_bus_sequencer_if.sv
// Host request/response stream plus the split PPI bus, seen from the
// host (master) and the sequencer (slave).
interface ppi_bus_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;
  logic       ppi_reset;
  logic       ppi_cs_n;
  logic       ppi_rd_n;
  logic       ppi_wr_n;
  logic [1:0] ppi_addr;
  logic [7:0] ppi_d_out;
  logic       ppi_d_oe;
  logic [7:0] ppi_d_in;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, ppi_d_in,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           ppi_reset, ppi_cs_n, ppi_rd_n, ppi_wr_n, ppi_addr, ppi_d_out, ppi_d_oe
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, ppi_d_in,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           ppi_reset, ppi_cs_n, ppi_rd_n, ppi_wr_n, ppi_addr, ppi_d_out, ppi_d_oe
  );
endinterface

// File: rtl/ppi_req_fifo.sv
// Small synchronous request FIFO. Exposes next-cycle full/empty so the
// sequencer can keep req_ready and busy registered.
module ppi_req_fifo
  import ppi_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic     CLK,
  input  logic     RESET,
  input  logic     push,
  input  logic     pop,
  input  ppi_req_t din,
  output ppi_req_t dout,
  output logic     full,
  output logic     empty,
  output logic     full_next,
  output logic     empty_next
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  typedef logic [AW:0] lvl_t;

  ppi_req_t      mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  lvl_t          level, level_d;

  always_comb begin
    level_d = level + lvl_t'(push) - lvl_t'(pop);
  end

  assign full       = (level == lvl_t'(FIFO_DEPTH));
  assign empty      = (level == '0);
  assign full_next  = (level_d == lvl_t'(FIFO_DEPTH));
  assign empty_next = (level_d == '0);
  assign dout       = mem[rptr];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      level <= level_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= din;
  end

endmodule

// File: rtl/ppi_bus_sequencer.sv
// Host-side 8255 PPI controller: buffers read/write requests and plays
// them out as timed CS/RD/WR bus cycles, with a PPI reset pulse at start.
module ppi_bus_sequencer
  import ppi_pkg::*;
#(
  parameter int FIFO_DEPTH  = 2,
  parameter int INIT_CYC    = 4,
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 2,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 1
) (
  input logic               CLK,
  input logic               RESET,
  ppi_bus_sequencer_if.slave bus
);
  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  ppi_req_t   cur, cur_d, req_in, dout;
  logic       push, pop, full, empty, full_next, empty_next;

  logic       in_bus, bus_end, ill;
  logic       cs_n_d, rd_n_d, wr_n_d, d_oe_d, ppi_reset_d;
  logic       req_ready_d, busy_d, rsp_valid_d, rsp_err_d;
  logic [1:0] addr_d;
  logic [7:0] d_out_d, rsp_rdata_d;

  assign req_in = {bus.req_wr, bus.req_addr, bus.req_wdata};
  assign push   = bus.req_valid && bus.req_ready && !full;
  assign pop    = (state == IDLE) && !empty;

  ppi_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK        (CLK),
    .RESET      (RESET),
    .push       (push),
    .pop        (pop),
    .din        (req_in),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .full_next  (full_next),
    .empty_next (empty_next)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= INIT;
      cnt   <= 4'(INIT_CYC);
      cur   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      cur   <= cur_d;
    end
  end

  // Timed states load PARAM-1 on entry and leave when the count hits 0.
  always_comb begin
    state_d = state;
    cnt_d   = cnt - 4'd1;
    cur_d   = cur;
    case (state)
      INIT: if (cnt == 4'd0) state_d = IDLE;
      IDLE: begin
        cnt_d = cnt;
        if (pop) begin
          cur_d = dout;
          if (!is_illegal(dout)) begin
            state_d = SETUP;
            cnt_d   = 4'(SETUP_CYC - 1);
          end
        end
      end
      SETUP:   if (cnt == 4'd0) begin state_d = STROBE;  cnt_d = 4'(STROBE_CYC - 1);  end
      STROBE:  if (cnt == 4'd0) begin state_d = HOLD;    cnt_d = 4'(HOLD_CYC - 1);    end
      HOLD:    if (cnt == 4'd0) begin state_d = RECOVER; cnt_d = 4'(RECOVER_CYC - 1); end
      RECOVER: if (cnt == 4'd0) state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line
  // up with the state they belong to.
  always_comb begin
    in_bus      = state_d inside {SETUP, STROBE, HOLD};
    bus_end     = (state == STROBE) && (cnt == 4'd0);
    ill         = pop && is_illegal(dout);
    ppi_reset_d = (state_d == INIT);
    cs_n_d      = !in_bus;
    rd_n_d      = !((state_d == STROBE) && !cur_d.wr);
    wr_n_d      = !((state_d == STROBE) && cur_d.wr);
    addr_d      = in_bus ? cur_d.addr : bus.ppi_addr;
    d_oe_d      = in_bus && cur_d.wr;
    d_out_d     = (in_bus && cur_d.wr) ? cur_d.wdata : bus.ppi_d_out;
    req_ready_d = !full_next && (state_d != INIT);
    busy_d      = !empty_next || (state_d != IDLE);
    rsp_valid_d = bus_end || ill;
    rsp_err_d   = ill;
    rsp_rdata_d = (bus_end && !cur.wr) ? bus.ppi_d_in : 8'h00;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 8'h00;
      bus.rsp_err   <= 1'b0;
      bus.busy      <= 1'b1;
      bus.ppi_reset <= 1'b1;
      bus.ppi_cs_n  <= 1'b1;
      bus.ppi_rd_n  <= 1'b1;
      bus.ppi_wr_n  <= 1'b1;
      bus.ppi_addr  <= 2'b00;
      bus.ppi_d_out <= 8'h00;
      bus.ppi_d_oe  <= 1'b0;
    end else begin
      bus.req_ready <= req_ready_d;
      bus.rsp_valid <= rsp_valid_d;
      bus.rsp_rdata <= rsp_rdata_d;
      bus.rsp_err   <= rsp_err_d;
      bus.busy      <= busy_d;
      bus.ppi_reset <= ppi_reset_d;
      bus.ppi_cs_n  <= cs_n_d;
      bus.ppi_rd_n  <= rd_n_d;
      bus.ppi_wr_n  <= wr_n_d;
      bus.ppi_addr  <= addr_d;
      bus.ppi_d_out <= d_out_d;
      bus.ppi_d_oe  <= d_oe_d;
    end
  end

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Directed bench for ppi_bus_sequencer at default timing; outputs are
// sampled on the falling edge into per-cycle trace arrays.
module tb_ppi_bus_sequencer;
  import ppi_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   passed = 0;

  ppi_bus_sequencer_if bus();

  ppi_bus_sequencer #(
    .FIFO_DEPTH(2), .INIT_CYC(4), .SETUP_CYC(1),
    .STROBE_CYC(2), .HOLD_CYC(1), .RECOVER_CYC(1)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic       c_cs[64], c_rd[64], c_wr[64], c_oe[64], c_rv[64], c_err[64];
  logic       c_rdy[64], c_prst[64], c_busy[64];
  logic [7:0] c_dout[64], c_rdata[64];
  logic [1:0] c_addr[64];

  // Records n falling-edge samples; ppi_d_in carries rdval only while RD_n is low.
  task automatic capture(input int n, input logic [7:0] rdval);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      c_cs[i]    = bus.ppi_cs_n;   c_rd[i]    = bus.ppi_rd_n;
      c_wr[i]    = bus.ppi_wr_n;   c_oe[i]    = bus.ppi_d_oe;
      c_rv[i]    = bus.rsp_valid;  c_err[i]   = bus.rsp_err;
      c_rdy[i]   = bus.req_ready;  c_prst[i]  = bus.ppi_reset;
      c_busy[i]  = bus.busy;       c_dout[i]  = bus.ppi_d_out;
      c_rdata[i] = bus.rsp_rdata;  c_addr[i]  = bus.ppi_addr;
      bus.ppi_d_in = bus.ppi_rd_n ? 8'h00 : rdval;
    end
  endtask

  task automatic send(input logic wr, input logic [1:0] addr, input logic [7:0] wd);
    int g = 0;
    @(negedge CLK);
    bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_addr = addr; bus.req_wdata = wd;
    while (!bus.req_ready && g < 50) begin @(negedge CLK); g++; end
    if (g >= 50) begin
      checks++;
      $display("FAIL send_timeout: req_ready stayed %b, required 1", bus.req_ready);
    end
    @(posedge CLK);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    RESET = 1'b0;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = 2'b00;
    bus.req_wdata = 8'h00; bus.ppi_d_in = 8'h00;
    repeat (3) @(negedge CLK);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.busy, bus.ppi_reset, bus.ppi_cs_n,
         bus.ppi_rd_n, bus.ppi_wr_n, bus.ppi_d_oe} !== 9'b000111110)
      $display("FAIL reset_ctrl: got %b required 000111110",
        {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.busy, bus.ppi_reset, bus.ppi_cs_n,
         bus.ppi_rd_n, bus.ppi_wr_n, bus.ppi_d_oe});
    else passed++;
    checks++;
    if ({bus.rsp_rdata, bus.ppi_addr, bus.ppi_d_out} !== 18'h0)
      $display("FAIL reset_data: rdata=%h addr=%b d_out=%h required 0",
        bus.rsp_rdata, bus.ppi_addr, bus.ppi_d_out);
    else passed++;
    RESET = 1'b1;
    capture(8, 8'h00);
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(c_prst[i]);
    checks++;
    if (n != 4 || c_prst[3] !== 1'b1) $display("FAIL init_len: ppi_reset high %0d cycles, required 4", n);
    else passed++;
    checks++;
    if (c_rdy[3] !== 1'b0 || c_rdy[4] !== 1'b1)
      $display("FAIL init_ready: ready[3]=%b ready[4]=%b required 0,1", c_rdy[3], c_rdy[4]);
    else passed++;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(!c_cs[i]) + int'(!c_rd[i]) + int'(!c_wr[i]);
    checks++;
    if (n != 0) $display("FAIL init_strobes: %0d low strobe samples, required 0", n);
    else passed++;
  endtask

  // Push lands at the edge after sample 0; pop at the next; SETUP is sample 2.
  task automatic test_write();
    int ncs, nwr, ngood, nrv;
    fork
      send(1'b1, ADDR_A, 8'hAA);
      capture(10, 8'h00);
    join
    ncs = 0; nwr = 0; ngood = 0; nrv = 0;
    for (int i = 0; i < 10; i++) begin
      ncs += int'(!c_cs[i]);
      nwr += int'(!c_wr[i]);
      nrv += int'(c_rv[i]);
      if (!c_cs[i] && c_oe[i] && c_dout[i] == 8'hAA && c_addr[i] == ADDR_A) ngood++;
    end
    checks++;
    if (ncs != 4 || c_cs[2] !== 1'b0 || c_cs[5] !== 1'b0)
      $display("FAIL wr_cs: cs low %0d cycles, required 4 at samples 2..5", ncs);
    else passed++;
    checks++;
    if (nwr != 2 || c_wr[3] !== 1'b0 || c_wr[4] !== 1'b0)
      $display("FAIL wr_strobe: wr_n low %0d cycles, required 2 at samples 3..4", nwr);
    else passed++;
    checks++;
    if (ngood != 4) $display("FAIL wr_drive: %0d cycles with oe=1 d_out=AA addr=00, required 4", ngood);
    else passed++;
    checks++;
    if (nrv != 1 || c_rv[5] !== 1'b1 || c_rdata[5] !== 8'h00 || c_err[5] !== 1'b0)
      $display("FAIL wr_rsp: pulses=%0d rv5=%b rdata=%h err=%b required 1,1,00,0",
        nrv, c_rv[5], c_rdata[5], c_err[5]);
    else passed++;
  endtask

  task automatic test_read();
    int ncs, nrd, noe, nwr;
    fork
      send(1'b0, ADDR_B, 8'h00);
      capture(10, 8'h5C);
    join
    ncs = 0; nrd = 0; noe = 0; nwr = 0;
    for (int i = 0; i < 10; i++) begin
      ncs += int'(!c_cs[i]); nrd += int'(!c_rd[i]);
      noe += int'(c_oe[i]);  nwr += int'(!c_wr[i]);
    end
    checks++;
    if (nrd != 2 || c_rd[3] !== 1'b0 || c_rd[4] !== 1'b0 || nwr != 0)
      $display("FAIL rd_strobe: rd_n low %0d, wr_n low %0d, required 2 and 0", nrd, nwr);
    else passed++;
    checks++;
    if (noe != 0 || ncs != 4 || c_addr[2] !== ADDR_B)
      $display("FAIL rd_bus: oe samples=%0d cs low=%0d addr=%b required 0,4,01", noe, ncs, c_addr[2]);
    else passed++;
    checks++;
    if (c_rv[5] !== 1'b1 || c_rdata[5] !== 8'h5C || c_err[5] !== 1'b0)
      $display("FAIL rd_rsp: rv=%b rdata=%h err=%b required 1,5c,0", c_rv[5], c_rdata[5], c_err[5]);
    else passed++;
  endtask

  // Depth-2 FIFO fills after the third push; bus cycles repeat every 6
  // cycles (4 with cs_n low, RECOVER, then the IDLE pop cycle).
  task automatic test_back_to_back();
    int starts[4];
    int nruns, nrv, nerr;
    fork
      begin
        send(1'b1, ADDR_CTRL, 8'h80);
        send(1'b1, ADDR_A, 8'h3C);
        send(1'b0, ADDR_C, 8'h00);
      end
      capture(24, 8'hC3);
    join
    checks++;
    if (c_rdy[2] !== 1'b1 || c_rdy[3] !== 1'b0)
      $display("FAIL b2b_ready: ready[2]=%b ready[3]=%b required 1,0", c_rdy[2], c_rdy[3]);
    else passed++;
    nruns = 0; nrv = 0; nerr = 0;
    for (int i = 1; i < 24; i++) begin
      if (!c_cs[i] && c_cs[i-1]) begin
        if (nruns < 4) starts[nruns] = i;
        nruns++;
      end
      nrv += int'(c_rv[i]); nerr += int'(c_err[i]);
    end
    checks++;
    if (nruns != 3 || starts[0] != 2 || starts[1] != 8 || starts[2] != 14)
      $display("FAIL b2b_timing: runs=%0d starts=%0d,%0d,%0d required 3 at 2,8,14",
        nruns, starts[0], starts[1], starts[2]);
    else passed++;
    checks++;
    if (c_addr[2] !== ADDR_CTRL || c_dout[2] !== 8'h80 || c_wr[3] !== 1'b0 || c_oe[2] !== 1'b1)
      $display("FAIL b2b_req0: addr=%b d_out=%h wr_n=%b oe=%b required 11,80,0,1",
        c_addr[2], c_dout[2], c_wr[3], c_oe[2]);
    else passed++;
    checks++;
    if (c_addr[8] !== ADDR_A || c_dout[8] !== 8'h3C || c_wr[9] !== 1'b0 || c_cs[6] !== 1'b1)
      $display("FAIL b2b_req1: addr=%b d_out=%h wr_n=%b gap cs=%b required 00,3c,0,1",
        c_addr[8], c_dout[8], c_wr[9], c_cs[6]);
    else passed++;
    checks++;
    if (c_addr[14] !== ADDR_C || c_rd[15] !== 1'b0 || c_wr[15] !== 1'b1 || c_oe[14] !== 1'b0)
      $display("FAIL b2b_req2: addr=%b rd_n=%b wr_n=%b oe=%b required 10,0,1,0",
        c_addr[14], c_rd[15], c_wr[15], c_oe[14]);
    else passed++;
    checks++;
    if (nrv != 3 || nerr != 0 || c_rv[17] !== 1'b1 || c_rdata[17] !== 8'hC3 || c_rdata[11] !== 8'h00)
      $display("FAIL b2b_rsp: pulses=%0d errs=%0d rdata17=%h rdata11=%h required 3,0,c3,00",
        nrv, nerr, c_rdata[17], c_rdata[11]);
    else passed++;
  endtask

  task automatic test_illegal();
    int ncs, nrv;
    fork
      send(1'b0, ADDR_CTRL, 8'h00);
      capture(8, 8'h00);
    join
    ncs = 0; nrv = 0;
    for (int i = 0; i < 8; i++) begin ncs += int'(!c_cs[i]) + int'(!c_rd[i]); nrv += int'(c_rv[i]); end
    checks++;
    if (ncs != 0) $display("FAIL ill_bus: %0d low cs/rd samples, required 0", ncs);
    else passed++;
    checks++;
    if (nrv != 1 || c_rv[2] !== 1'b1 || c_err[2] !== 1'b1 || c_rdata[2] !== 8'h00)
      $display("FAIL ill_rsp: pulses=%0d rv=%b err=%b rdata=%h required 1,1,1,00",
        nrv, c_rv[2], c_err[2], c_rdata[2]);
    else passed++;
    checks++;
    if (c_busy[1] !== 1'b1 || c_busy[2] !== 1'b0)
      $display("FAIL ill_busy: busy[1]=%b busy[2]=%b required 1,0", c_busy[1], c_busy[2]);
    else passed++;
  endtask

  task automatic test_reset_mid_strobe();
    int g, n, nrv, ncs;
    g = 0;
    fork
      send(1'b1, ADDR_B, 8'h55);
      begin
        do begin @(negedge CLK); g++; end while (bus.ppi_wr_n !== 1'b0 && g < 20);
      end
    join
    checks++;
    if (g >= 20) $display("FAIL mid_wait: wr_n never went low, last %b required 0", bus.ppi_wr_n);
    else passed++;
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if ({bus.ppi_wr_n, bus.ppi_cs_n, bus.ppi_d_oe, bus.rsp_valid, bus.ppi_reset, bus.req_ready, bus.busy}
        !== 7'b1100101)
      $display("FAIL mid_abort: wr_n,cs_n,oe,rv,prst,rdy,busy=%b required 1100101",
        {bus.ppi_wr_n, bus.ppi_cs_n, bus.ppi_d_oe, bus.rsp_valid, bus.ppi_reset, bus.req_ready, bus.busy});
    else passed++;
    @(negedge CLK);
    RESET = 1'b1;
    capture(10, 8'h00);
    n = 0; nrv = 0; ncs = 0;
    for (int i = 0; i < 10; i++) begin
      n += int'(c_prst[i]); nrv += int'(c_rv[i]); ncs += int'(!c_cs[i]);
    end
    checks++;
    if (n != 4 || c_prst[3] !== 1'b1) $display("FAIL mid_init: ppi_reset high %0d cycles, required 4", n);
    else passed++;
    checks++;
    if (nrv != 0 || ncs != 0 || c_busy[9] !== 1'b0)
      $display("FAIL mid_flush: rsp=%0d cs low=%0d busy=%b required 0,0,0", nrv, ncs, c_busy[9]);
    else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_illegal();
    test_reset_mid_strobe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
